// File: rtl/rc4_pkg.sv
// Shared RC4 pipeline types and constants: memory geometry, key defaults and stage FSM encodings.
package rc4_pkg;

  localparam int unsigned MEM_DEPTH       = 256;
  localparam int unsigned KEY_BITS        = 24;
  localparam int unsigned KEY_LEN_DEFAULT = 3;

  typedef enum logic [2:0] {
    IDLE,
    RD_I,
    LATCH_I,
    RD_J,
    LATCH_J,
    WR_I,
    WR_J,
    DONE
  } ksa_state_t;

  typedef enum logic [1:0] {
    INIT_IDLE,
    INIT_FILL,
    INIT_DONE
  } init_state_t;

endpackage

// File: rtl/ksa_key_sel.sv
// Key byte selector: a mod-KEY_LEN index that steps with i, muxing one byte out of the packed key.
module ksa_key_sel
  import rc4_pkg::*;
#(
  parameter int unsigned KEY_LEN = KEY_LEN_DEFAULT
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_adv,
  input  logic [KEY_BITS-1:0] i_key,
  output logic [7:0]          o_key_byte
);

  localparam int unsigned    IdxW    = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(KEY_LEN - 1);

  logic [IdxW-1:0] r_idx;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx <= '0;
    end else if (i_adv) begin
      r_idx <= (r_idx == LastIdx) ? '0 : r_idx + 1'b1;
    end
  end

  // Byte 0 is the most significant byte of the key; KEY_LEN must not exceed KEY_BITS/8.
  always_comb begin
    o_key_byte = '0;
    for (int unsigned k = 0; k < KEY_LEN; k++) begin
      if (r_idx == IdxW'(k)) begin
        o_key_byte = i_key[KEY_BITS-1-8*k -: 8];
      end
    end
  end

endmodule

// File: rtl/ksa.sv
// RC4 key-scheduling stage: 256 read/read/write/write swap iterations over an external S memory.
module ksa
  import rc4_pkg::*;
#(
  parameter int unsigned KEY_LEN = KEY_LEN_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KEY_BITS-1:0] secret_key,
  input  logic [7:0]          s_q,
  output logic [7:0]          s_address,
  output logic [7:0]          s_data,
  output logic                s_wren,
  output logic                done
);

  localparam logic [7:0] LastIdx = 8'(MEM_DEPTH - 1);

  ksa_state_t r_state;
  logic [7:0] r_i;
  logic [7:0] r_j;
  logic [7:0] r_si;
  logic [7:0] r_sj;

  logic [7:0] w_key_byte;
  logic [7:0] w_j_next;
  logic       w_key_adv;

  assign w_j_next  = r_j + s_q + w_key_byte;
  assign w_key_adv = (r_state == WR_J) && (r_i != LastIdx);

  ksa_key_sel #(
    .KEY_LEN (KEY_LEN)
  ) u_key_sel (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_adv      (w_key_adv),
    .i_key      (secret_key),
    .o_key_byte (w_key_byte)
  );

  // Outputs are registered on the transition into each state, so they hold for that state's cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_i       <= '0;
      r_j       <= '0;
      r_si      <= '0;
      r_sj      <= '0;
      s_address <= '0;
      s_data    <= '0;
      s_wren    <= 1'b0;
      done      <= 1'b0;
    end else begin
      s_address <= r_i;
      s_data    <= '0;
      s_wren    <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) r_state <= RD_I;
        end
        RD_I: begin
          r_state <= LATCH_I;
        end
        LATCH_I: begin
          r_si      <= s_q;
          r_j       <= w_j_next;
          s_address <= w_j_next;
          r_state   <= RD_J;
        end
        RD_J: begin
          r_state <= LATCH_J;
        end
        LATCH_J: begin
          r_sj    <= s_q;
          s_data  <= s_q;
          s_wren  <= 1'b1;
          r_state <= WR_I;
        end
        WR_I: begin
          s_address <= r_j;
          s_data    <= r_si;
          s_wren    <= 1'b1;
          r_state   <= WR_J;
        end
        WR_J: begin
          if (r_i == LastIdx) begin
            done    <= 1'b1;
            r_state <= DONE;
          end else begin
            r_i       <= r_i + 8'd1;
            s_address <= r_i + 8'd1;
            r_state   <= RD_I;
          end
        end
        DONE: begin
          done <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ksa.sv
// Bench for ksa: 1-cycle-latency S RAM, high-level RC4 KSA reference model, randomized keys.
module tb_ksa;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] secret_key;
  logic [7:0]  s_q;
  logic [7:0]  s_address;
  logic [7:0]  s_data;
  logic        s_wren;
  logic        done;

  always #5 clk = ~clk;

  ksa #(
    .KEY_LEN (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .secret_key (secret_key),
    .s_q        (s_q),
    .s_address  (s_address),
    .s_data     (s_data),
    .s_wren     (s_wren),
    .done       (done)
  );

  // Behavioural S memory with registered read data.
  logic [7:0] mem [256];
  logic       ram_init;
  logic [7:0] ram_q;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (s_wren) begin
      mem[s_address] <= s_data;
    end
    ram_q <= mem[s_address];
  end
  assign s_q = ram_q;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          wr_cnt  = 0;
  int          idle_data_bad = 0;
  int          cyc_ctr = 0;
  int          start_cyc = 0;
  logic [7:0]  last_wr_addr;
  logic [15:0] exp_q[$];
  logic [7:0]  ref_s [256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc_ctr++;

  // Every write must be the next one the reference model predicts.
  always @(negedge clk) begin
    if (s_wren === 1'b1) begin
      wr_cnt++;
      last_wr_addr = s_address;
      if (exp_q.size() == 0) check("wr_queue_nonempty", 32'(exp_q.size()), 32'd1);
      else check("wr_addr_data", {16'h0, s_address, s_data}, {16'h0, exp_q.pop_front()});
    end else if (s_data !== 8'h00) begin
      idle_data_bad++;
    end
  end

  // Straight RC4 KSA over an array; records the expected write stream and final S.
  task automatic build_ref(input logic [23:0] key);
    logic [7:0] s [256];
    logic [7:0] kb [3];
    logic [7:0] t;
    int         j = 0;
    kb[0] = key[23:16];
    kb[1] = key[15:8];
    kb[2] = key[7:0];
    exp_q.delete();
    for (int k = 0; k < 256; k++) s[k] = 8'(k);
    for (int i = 0; i < 256; i++) begin
      j = (j + int'(s[i]) + int'(kb[i % 3])) % 256;
      exp_q.push_back({8'(i), s[j]});
      exp_q.push_back({8'(j), s[i]});
      t    = s[i];
      s[i] = s[j];
      s[j] = t;
    end
    for (int k = 0; k < 256; k++) ref_s[k] = s[k];
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    start    = 1'b0;
    ram_init = 1'b1;
    @(posedge clk);
    #1;
    check("rst_wren", 32'(s_wren), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", 32'(s_address), 32'd0);
    check("rst_data", 32'(s_data), 32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    ram_init = 1'b0;
    exp_q.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic start_run(input logic [23:0] key);
    secret_key    = key;
    build_ref(key);
    wr_cnt        = 0;
    idle_data_bad = 0;
    pulse_start();
    start_cyc = cyc_ctr;
  endtask

  task automatic wait_writes(input int n);
    int guard = 0;
    while (wr_cnt < n && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (wr_cnt < n) check("wait_writes_timeout", 32'(wr_cnt), 32'(n));
  endtask

  task automatic finish_run();
    int guard = 0;
    int mism  = 0;
    int miss  = 0;
    int seen [256];
    while (done !== 1'b1 && guard < 3000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("done_latency", 32'(cyc_ctr - start_cyc), 32'd1536);
    check("wr_total", 32'(wr_cnt), 32'd512);
    check("wr_left", 32'(exp_q.size()), 32'd0);
    check("idle_data_zero", 32'(idle_data_bad), 32'd0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 256; k++) seen[k] = 0;
    for (int k = 0; k < 256; k++) begin
      if (mem[k] !== ref_s[k]) mism++;
      if (!$isunknown(mem[k])) seen[mem[k]]++;
    end
    for (int k = 0; k < 256; k++) if (seen[k] != 1) miss++;
    check("final_s", 32'(mism), 32'd0);
    check("perm", 32'(miss), 32'd0);
    pulse_start();
    repeat (20) @(posedge clk);
    #1;
    check("post_done_wr", 32'(wr_cnt), 32'd512);
    check("post_done_hold", 32'(done), 32'd1);
    check("post_done_wren", 32'(s_wren), 32'd0);
  endtask

  initial begin
    logic [23:0] key;
    int          guard;
    rst        = 1'b1;
    start      = 1'b0;
    ram_init   = 1'b0;
    secret_key = '0;

    // Known-answer key with early-iteration checkpoints.
    do_reset();
    start_run(24'h000249);
    wait_writes(2);
    check("it0_s0", 32'(mem[0]), 32'h00);
    wait_writes(4);
    check("it1_s1", 32'(mem[1]), 32'h03);
    check("it1_s3", 32'(mem[3]), 32'h01);
    wait_writes(6);
    check("it2_j", 32'(last_wr_addr), 32'h4E);
    check("it2_s2", 32'(mem[2]), 32'h4E);
    check("it2_s4e", 32'(mem[8'h4E]), 32'h02);
    finish_run();

    // j wraps modulo 256.
    do_reset();
    start_run(24'hFFFFFF);
    wait_writes(2);
    check("wrap_j", 32'(last_wr_addr), 32'hFF);
    check("wrap_s0", 32'(mem[0]), 32'hFF);
    check("wrap_sff", 32'(mem[8'hFF]), 32'h00);
    finish_run();

    // i == j on the first iteration.
    do_reset();
    start_run(24'h000000);
    wait_writes(2);
    check("self_swap_s0", 32'(mem[0]), 32'h00);
    finish_run();

    for (int r = 0; r < 2; r++) begin
      do_reset();
      start_run(24'($urandom));
      finish_run();
    end

    // Abort during WR_I of iteration 100, then restart from scratch.
    key = 24'($urandom);
    do_reset();
    start_run(key);
    wait_writes(200);
    guard = 0;
    while (s_wren !== 1'b1 && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("abort_in_wr_i", 32'(s_address), 32'd100);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_wren", 32'(s_wren), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_more_wr", 32'(wr_cnt), 32'd201);
    do_reset();
    start_run(key);
    finish_run();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ksa.md
KSA -- requirements
Module: ksa

Interface
REQ-001 SHALL have parameter KEY_LEN, default 3, meaning number of secret-key bytes used cyclically.
REQ-002 SHALL have port clk, input, 1 bit: single system clock (CLK_50); all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: begin key scheduling; driven by the init stage's done; high means go.
REQ-005 SHALL have port secret_key, input, 24 bits: key; byte 0 = [23:16], byte 1 = [15:8], byte 2 = [7:0].
REQ-006 SHALL have port s_q, input, 8 bits: read data from s_memory.
REQ-007 SHALL have port s_address, output, 8 bits: address into s_memory.
REQ-008 SHALL have port s_data, output, 8 bits: write data into s_memory.
REQ-009 SHALL have port s_wren, output, 1 bit: s_memory write enable.
REQ-010 SHALL have port done, output, 1 bit: high once all 256 swaps complete.

Function
REQ-011 SHALL perform, for i = 0..255: j = j + S[i] + key[i mod KEY_LEN]; then swap S[i] and S[j]; i and j both start at 0.
REQ-012 SHALL do all i/j arithmetic in 8 bits, modulo 256, with carries discarded.
REQ-013 SHALL take s_q as valid in the cycle after the cycle that drove s_address with s_wren = 0 (one-cycle read latency).
REQ-014 SHALL use the states IDLE, RD_I, LATCH_I, RD_J, LATCH_J, WR_I, WR_J, DONE.
REQ-015 In IDLE, SHALL stay in IDLE with s_wren = 0; SHALL go to RD_I when start = 1; SHALL ignore start in every other state.
REQ-016 In RD_I, SHALL drive s_address = i, s_wren = 0.
REQ-017 In LATCH_I, SHALL register si <= s_q and update j <= j + s_q + key byte.
REQ-018 In RD_J, SHALL drive s_address = j (updated value), s_wren = 0.
REQ-019 In LATCH_J, SHALL register sj <= s_q.
REQ-020 In WR_I, SHALL drive s_address = i, s_data = sj, s_wren = 1.
REQ-021 In WR_J, SHALL drive s_address = j, s_data = si, s_wren = 1; if i = 255 go to DONE, else increment i and go to RD_I.
REQ-022 SHALL select the key byte with a mod-KEY_LEN counter that advances with i and resets to 0 with i (no divider).
REQ-023 When i == j, SHALL perform both writes anyway; S[i] is left unchanged.
REQ-024 SHALL take exactly 6 cycles per iteration, i.e. 1536 cycles from the first RD_I to entering DONE.
REQ-025 In DONE, SHALL hold done = 1 and s_wren = 0 until rst, and SHALL ignore start.
REQ-026 In non-write states, SHALL keep s_data = 0; s_address follows REQ-016..021 and is i in the remaining states.

Reset
REQ-027 When rst = 1 at a clock edge, SHALL set state = IDLE, i = 0, j = 0, key index = 0, si = sj = 0.
REQ-028 During and after reset, SHALL drive s_wren = 0, done = 0, s_address = 0, s_data = 0.
REQ-029 On reset mid-operation, SHALL abort immediately with no further writes; a later start restarts from i = 0, j = 0.

Structure
REQ-030 SHALL take the state enum type, the KEY_LEN default and the memory depth constant 256 from shared package rc4_pkg, alongside the init stage's types.
REQ-031 SHALL contain one sub-module, ksa_key_sel, a mod-KEY_LEN counter plus byte mux; all else stays in ksa.
REQ-032 SHALL NOT contain s_memory; ksa is its single write master after the init stage finishes.

Verification
REQ-033 With behavioural 1-cycle-latency RAM holding S[k] = k and key 0x000249: after iteration 0, S[0] = 0; after iteration 1, S[1] = 0x03 and S[3] = 0x01; after iteration 2, j = 0x4E, S[2] = 0x4E and S[0x4E] = 0x02.
REQ-034 With key 0xFFFFFF on identity S: iteration 0 gives j = 0xFF, S[0] = 0xFF, S[0xFF] = 0x00 (wrap check).
REQ-035 With key 0x000000, iteration 0 (i == j == 0): two writes of 0x00 to address 0; S[0] stays 0x00.
REQ-036 One start pulse: done rises exactly 1536 cycles after the first RD_I; exactly 512 write cycles occur in total; further start pulses cause no writes.
REQ-037 Assert rst at iteration 100 during WR_I: next cycle s_wren = 0, done = 0; re-init the RAM and restart; the final S matches the reference model for the key.
REQ-038 Across all runs: final S is a permutation of 0..255 and s_wren is never high in IDLE, RD_*, LATCH_* or DONE.
